i2s_playback_sequencer: RTL and testbench
=========================================

Name: i2s_playback_sequencer

Overview:
- Sequences PCM playback from a block ROM into the i2s_controller.
- Walks a programmable address window, fetches each 16-bit sample with ROM latency accounted for, and presents it as a left word then a right word over a valid/ready handshake.
- Supports play, stop and loop, and drives amplifier shutdown.
- Sits between block_rom and i2s_controller in main, replacing ad-hoc sequencing there.

Parameters:
- W, 16, sample width in bits.
- L, 50000, ROM depth in words.
- AW, $clog2(L), address width.
- ROM_LAT, 1, cycles from rom_addr change to valid rom_data (1..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- play  in  1  start pulse.
- stop  in  1  stop request pulse.
- loop_en  in  1  restart at start_addr after end_addr.
- start_addr  in  AW  first sample, sampled on accepted play.
- end_addr  in  AW  last sample, inclusive, sampled on accepted play.
- rom_addr  out  AW  ROM read address, registered.
- rom_data  in  W  ROM read data.
- o_data  out  W  sample to I2S.
- o_ws  out  1  channel tag: 1 = left, 0 = right.
- o_valid  out  1  o_data/o_ws valid.
- i_ready  in  1  I2S ready.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at natural end of a non-looping pass.
- err  out  1  sticky; set by rejected play.
- shutdown  out  1  amplifier enable, active-low sense as in main; 1 = amp on.

Behaviour:
- Reset (async, immediate, any state): state=IDLE; rom_addr=0; o_valid=0; o_ws=0; o_data=0; busy=0; done=0; err=0; shutdown=0.
- States: IDLE, FETCH, SEND_L, SEND_R, ADVANCE, DONE.
- IDLE:
  - play with start_addr<=end_addr<L and no stop: latch window, rom_addr<=start_addr, clear err, go to FETCH.
  - Otherwise play sets err and the state stays IDLE.
- FETCH: wait counter runs ROM_LAT cycles after the address update, then latch rom_data into a sample register and go to SEND_L.
- SEND_L:
  - o_valid=1, o_ws=1, o_data=sample.
  - Transfer occurs on a cycle with o_valid & i_ready; then go to SEND_R.
  - o_valid, o_data and o_ws are held stable until the transfer.
- SEND_R: same as SEND_L with o_ws=0 and the same sample. On transfer go to ADVANCE.
- ADVANCE:
  - If stop is pending: go to IDLE.
  - Else if rom_addr!=end_addr: rom_addr+1, go to FETCH.
  - Else if loop_en: rom_addr<=start_addr, go to FETCH.
  - Else go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Throughput: per sample, 1 + ROM_LAT + 2 transfers + 1 cycles minimum.
- stop:
  - Latched into a pending flag in any non-IDLE state.
  - The current L/R pair is always completed; a frame is never split.
  - Honoured in ADVANCE, without asserting done. The pending flag clears on entering IDLE.
- play and stop in the same IDLE cycle: stop wins, play is ignored and err is unchanged.
- play while busy: ignored.
- loop_en is sampled live in ADVANCE.
- Single-sample window (start==end) is legal: plays once, or repeats if looping.
- rom_addr never exceeds end_addr and never wraps past L-1.
- shutdown=1 in FETCH/SEND_L/SEND_R/ADVANCE, 0 in IDLE/DONE.
- All outputs are registered except o_valid, which is decoded from state.

Optional Feature:
- Macro: I2S_SEQ_ATTEN_EN.
- Defined:
  - Adds input vol_shift [3:0].
  - The sample register loads rom_data arithmetically right-shifted (sign-preserving) by vol_shift, sampled in FETCH.
  - vol_shift>=W yields all sign bits.
- Undefined: port absent; sample = rom_data unchanged.

Test Plan:
- Reset mid-SEND_L (o_valid=1): all outputs drop to reset values the same cycle rst rises; after release, no transfer occurs without a new play.
- start=10, end=12, loop_en=0, i_ready always 1, ROM word = address: transfers (L,10),(R,10),(L,11),(R,11),(L,12),(R,12); done pulses once; busy falls next cycle.
- Same window, i_ready toggling 1-of-3 cycles: identical transfer sequence; o_data/o_ws stable while o_valid & !i_ready.
- start=5, end=5, loop_en=1, stop asserted during the third SEND_L: exactly three full L/R pairs of sample 5; IDLE entered with no done pulse.
- play with start=20, end=19 → err=1, busy stays 0; play and stop together with a valid window → no start, err unchanged.
- Macro defined, rom_data=16'h8000, vol_shift=2 → o_data=16'hE000 on both L and R; macro undefined → 16'h8000.

Source files
------------

// File: rtl/i2s_playback_sequencer.sv
// i2s_playback_sequencer: walks a ROM address window, fetches each sample
// (allowing for the ROM read latency) and hands it to the I2S controller as a
// left word followed by a right word over a valid/ready handshake. Supports
// play/stop/loop and drives the amplifier enable.
//
// Optional build macro: I2S_SEQ_ATTEN_EN adds a vol_shift input. Each fetched
// sample is then arithmetically right-shifted by vol_shift, which keeps its sign.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | waiting for an accepted play; amplifier off
// FETCH   | rom_addr updated; wait out the ROM latency, then latch the sample
// SEND_L  | present the sample with ws=1 until the I2S side takes it
// SEND_R  | present the same sample with ws=0 until the I2S side takes it
// ADVANCE | honour a pending stop, or step/wrap the address, or finish
// DONE    | one-cycle done pulse after a non-looping pass, then IDLE
module i2s_playback_sequencer #(
    parameter int W       = 16,
    parameter int L       = 50000,
    parameter int AW      = $clog2(L),
    parameter int ROM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          play,
    input  logic          stop,
    input  logic          loop_en,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    output logic [AW-1:0] rom_addr,
    input  logic [W-1:0]  rom_data,
`ifdef I2S_SEQ_ATTEN_EN
    input  logic [3:0]    vol_shift,
`endif
    output logic [W-1:0]  o_data,
    output logic          o_ws,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          shutdown
);

    typedef enum logic [2:0] {IDLE, FETCH, SEND_L, SEND_R, ADVANCE, DONE} state_t;

    // FETCH lasts ROM_LAT+1 cycles, so the down-counter is loaded with ROM_LAT
    // and the sample is captured on the cycle it reads zero.
    localparam logic [2:0]  LAT_INIT = 3'(ROM_LAT);
    localparam logic [AW:0] L_LIM    = (AW+1)'(L);

    state_t        state, state_nxt;
    logic [AW-1:0] start_q, end_q, addr_nxt;
    logic [2:0]    cnt;
    logic          stop_pend;
    logic          win_ok, accept, reject, xfer, stop_hit;
    logic [W-1:0]  sample_in;

`ifdef I2S_SEQ_ATTEN_EN
    assign sample_in = W'($signed(rom_data) >>> vol_shift);
`else
    assign sample_in = rom_data;
`endif

    assign win_ok   = (start_addr <= end_addr) && ({1'b0, end_addr} < L_LIM);
    assign accept   = (state == IDLE) && play && !stop && win_ok;
    assign reject   = (state == IDLE) && play && !stop && !win_ok;
    assign o_valid  = (state == SEND_L) || (state == SEND_R);
    assign xfer     = o_valid && i_ready;
    assign stop_hit = stop_pend || stop;

    // Next-state and next-address decode
    always_comb begin
        state_nxt = state;
        addr_nxt  = rom_addr;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = FETCH;
                    addr_nxt  = start_addr;
                end
            end
            FETCH:  if (cnt == 3'd0) state_nxt = SEND_L;
            SEND_L: if (xfer) state_nxt = SEND_R;
            SEND_R: if (xfer) state_nxt = ADVANCE;
            ADVANCE: begin
                if (stop_hit) begin
                    state_nxt = IDLE;
                end else if (rom_addr != end_q) begin
                    addr_nxt  = rom_addr + AW'(1);
                    state_nxt = FETCH;
                end else if (loop_en) begin
                    addr_nxt  = start_q;
                    state_nxt = FETCH;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, address and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rom_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            shutdown <= 1'b0;
            o_ws     <= 1'b0;
        end else begin
            state    <= state_nxt;
            rom_addr <= addr_nxt;
            busy     <= (state_nxt != IDLE);
            done     <= (state_nxt == DONE);
            shutdown <= (state_nxt == FETCH) || (state_nxt == SEND_L) ||
                        (state_nxt == SEND_R) || (state_nxt == ADVANCE);
            o_ws     <= (state_nxt == SEND_L);
        end
    end

    // Window latch, sticky error and pending-stop flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q   <= '0;
            end_q     <= '0;
            err       <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            if (accept) begin
                start_q <= start_addr;
                end_q   <= end_addr;
                err     <= 1'b0;
            end else if (reject) begin
                err <= 1'b1;
            end
            if (state_nxt == IDLE)
                stop_pend <= 1'b0;
            else if (stop && (state != IDLE))
                stop_pend <= 1'b1;
        end
    end

    // ROM latency down-counter and sample capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            o_data <= '0;
        end else begin
            if ((state_nxt == FETCH) && (state != FETCH))
                cnt <= LAT_INIT;
            else if ((state == FETCH) && (cnt != 3'd0))
                cnt <= cnt - 3'd1;
            if ((state == FETCH) && (cnt == 3'd0))
                o_data <= sample_in;
        end
    end

endmodule

// File: tb/tb_i2s_playback_sequencer.sv
// Self-checking bench for i2s_playback_sequencer: directed plays with a
// scoreboard of expected (ws, data) words and a monitor that pops on transfers.
module tb_i2s_playback_sequencer;

    localparam int W       = 16;
    localparam int L       = 50000;
    localparam int AW      = $clog2(L);
    localparam int ROM_LAT = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          play = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [AW-1:0] start_addr = '0, end_addr = '0;
    logic [AW-1:0] rom_addr;
    logic [W-1:0]  rom_data;
    logic [W-1:0]  o_data;
    logic          o_ws, o_valid, busy, done, err, shutdown;
    logic          i_ready = 1'b1;
`ifdef I2S_SEQ_ATTEN_EN
    logic [3:0]    vol_shift = 4'd0;
`endif

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int rdy_mode = 0;
    logic [W:0] sb_q[$];

    i2s_playback_sequencer #(.W(W), .L(L), .AW(AW), .ROM_LAT(ROM_LAT)) dut (
        .clk(clk), .rst(rst), .play(play), .stop(stop), .loop_en(loop_en),
        .start_addr(start_addr), .end_addr(end_addr), .rom_addr(rom_addr),
        .rom_data(rom_data),
`ifdef I2S_SEQ_ATTEN_EN
        .vol_shift(vol_shift),
`endif
        .o_data(o_data), .o_ws(o_ws), .o_valid(o_valid), .i_ready(i_ready),
        .busy(busy), .done(done), .err(err), .shutdown(shutdown)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rom_word(input logic [AW-1:0] a);
        if (a == AW'(100)) return 16'h8000;
        if (a == AW'(101)) return 16'h7FFF;
        return W'(a);
    endfunction

    logic [W-1:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_word(rom_addr);
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    // i_ready pattern: 0 = always 1, 1 = high one cycle in three, 2 = always 0
    initial begin
        int c = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: i_ready = 1'b1;
                1: i_ready = (c % 3 == 0);
                default: i_ready = 1'b0;
            endcase
            c++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer, checks hold-stability
    logic         held_v = 1'b0, held_ws = 1'b0, prev_done = 1'b0;
    logic [W-1:0] held_d = '0;
    always @(negedge clk) begin
        if (rst) begin
            held_v    = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) chk("idle_after_done", {30'd0, busy, done}, 32'd0);
            prev_done = done;
            if (done) done_cnt++;
            if (o_valid) begin
                if (held_v) chk("hold_stable", {15'd0, o_ws, o_data}, {15'd0, held_ws, held_d});
                if (i_ready) begin
                    chk("shutdown_on", {31'd0, shutdown}, 32'd1);
                    if (sb_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_xfer: got ws=%b data=%h expected none", o_ws, o_data);
                    end else begin
                        logic [W:0] e;
                        e = sb_q.pop_front();
                        chk("xfer", {15'd0, o_ws, o_data}, {15'd0, e});
                    end
                    held_v = 1'b0;
                end else begin
                    held_v  = 1'b1;
                    held_d  = o_data;
                    held_ws = o_ws;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic push_pair(input logic [W-1:0] d);
        sb_q.push_back({1'b1, d});
        sb_q.push_back({1'b0, d});
    endtask

    task automatic issue_play(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic with_stop);
        @(posedge clk); #1;
        start_addr = s; end_addr = e; play = 1'b1; stop = with_stop;
        @(posedge clk); #1;
        play = 1'b0; stop = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int seen;
        logic [W-1:0] atn_a, atn_b;

        // Reset state
        #23;
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_outputs", {25'd0, o_valid, o_ws, busy, done, err, shutdown, |o_data}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Reset asserted mid-SEND_L
        rdy_mode = 2;
        issue_play(10, 12, 1'b0);
        seen = 0;
        while (!o_valid && seen < 50) begin @(negedge clk); seen++; end
        chk("reached_send_l", {30'd0, o_valid, o_ws}, 32'd3);
        rst = 1'b1; #1;
        chk("async_rst_addr", 32'(rom_addr), 32'd0);
        chk("async_rst_outs", {25'd0, o_valid, o_ws, busy, done, err, shutdown, |o_data}, 32'd0);
        @(posedge clk); #1; rst = 1'b0; rdy_mode = 0;
        repeat (10) @(posedge clk); #1;
        chk("no_restart_busy", {30'd0, busy, o_valid}, 32'd0);

        // Window 10..12, always ready
        for (int a = 10; a <= 12; a++) push_pair(W'(a));
        d0 = done_cnt;
        issue_play(10, 12, 1'b0);
        chk("busy_after_play", {31'd0, busy}, 32'd1);
        wait_idle(200);
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("sb_empty_1", 32'(sb_q.size()), 32'd0);

        // Same window, ready one cycle in three
        rdy_mode = 1;
        for (int a = 10; a <= 12; a++) push_pair(W'(a));
        d0 = done_cnt;
        issue_play(10, 12, 1'b0);
        wait_idle(400);
        chk("done_once_slow", 32'(done_cnt - d0), 32'd1);
        chk("sb_empty_2", 32'(sb_q.size()), 32'd0);
        rdy_mode = 0;

        // Single-sample loop, stop during the third SEND_L
        loop_en = 1'b1;
        for (int k = 0; k < 3; k++) push_pair(W'(5));
        d0 = done_cnt;
        issue_play(5, 5, 1'b0);
        seen = 0;
        for (int n = 0; n < 200 && seen < 3; n++) begin
            @(negedge clk);
            if (o_valid && o_ws && i_ready) seen++;
        end
        chk("third_send_l", 32'(seen), 32'd3);
        stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
        wait_idle(50);
        loop_en = 1'b0;
        repeat (5) @(posedge clk); #1;
        chk("stop_no_done", 32'(done_cnt - d0), 32'd0);
        chk("sb_empty_3", 32'(sb_q.size()), 32'd0);

        // Rejected windows and play+stop collision
        issue_play(20, 19, 1'b0);
        chk("bad_win_err", {30'd0, err, busy}, 32'd2);
        chk("err_sticky", {31'd0, err}, 32'd1);
        issue_play(10, 12, 1'b1);
        chk("play_stop_ignored", {30'd0, err, busy}, 32'd2);
        issue_play(0, AW'(L), 1'b0);
        chk("end_past_rom_err", {30'd0, err, busy}, 32'd2);
        for (int a = 10; a <= 12; a++) push_pair(W'(a));
        issue_play(10, 12, 1'b0);
        chk("err_cleared", {30'd0, err, busy}, 32'd1);
        wait_idle(200);

        // Sign handling on fetched samples
`ifdef I2S_SEQ_ATTEN_EN
        vol_shift = 4'd2;
        atn_a = 16'hE000; atn_b = 16'h1FFF;
`else
        atn_a = 16'h8000; atn_b = 16'h7FFF;
`endif
        push_pair(atn_a);
        push_pair(atn_b);
        issue_play(100, 101, 1'b0);
        wait_idle(200);
        chk("sb_empty_4", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
